// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: M-op funct3 codes, the funct7 that marks an M-op,
// and the multiply/divide sequencer state encoding.
package rv32m_pkg;

    localparam logic [6:0] M_FUNCT7 = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath: a radix-2 shift-add multiply step
// (mode=0) or a restoring trial-subtract divide step (mode=1).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            mode,
    input  logic [XLEN:0]   hi_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN:0]   hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;

    // Multiply: hi:lo is the product register, lo shifts out multiplier bits.
    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    always_comb begin
        sum     = hi_in + (lo_in[0] ? {1'b0, operand} : '0);
        shifted = {hi_in[XLEN-1:0], lo_in[XLEN-1]};
        hi_out  = '0;
        lo_out  = '0;
        if (!mode) begin
            hi_out = {1'b0, sum[XLEN:1]};
            lo_out = {sum[0], lo_in[XLEN-1:1]};
        end else if (shifted >= {1'b0, operand}) begin
            hi_out = shifted - {1'b0, operand};
            lo_out = {lo_in[XLEN-2:0], 1'b1};
        end else begin
            hi_out = shifted;
            lo_out = {lo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: stalls the pipeline via busy while it
// iterates, then pulses result_valid with the result and destination tag.
module muldiv_sequencer
    import rv32m_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [TAG_W-1:0] rd_in,
    output logic             ready,
    output logic             busy,
    output logic             result_valid,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] rd_out
);

    state_t            state, next_state;
    logic [5:0]        count;
    logic [2:0]        op_f3;
    logic              neg_res;
    logic [TAG_W-1:0]  rd_pending;
    logic [XLEN:0]     acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [XLEN-1:0]   operand_b;
    logic [XLEN:0]     step_hi;
    logic [XLEN-1:0]   step_lo;

    logic              accept;
    logic              sign_a, sign_b, neg_next;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_val;
    logic [2*XLEN-1:0] product, product_fix;
    logic [XLEN-1:0]   fixed;

    assign accept = (state == IDLE) && start && !flush;

    // Operand preparation and the divide corner cases resolved at accept time.
    always_comb begin
        sign_a   = ((funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                    (funct3 == F3_DIV)  || (funct3 == F3_REM)) && rs1_val[XLEN-1];
        sign_b   = ((funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                    (funct3 == F3_REM)) && rs2_val[XLEN-1];
        abs_a    = sign_a ? -rs1_val : rs1_val;
        abs_b    = sign_b ? -rs2_val : rs2_val;
        neg_next = 1'b0;
        case (funct3)
            F3_MULH, F3_MULHSU, F3_DIV: neg_next = sign_a ^ sign_b;
            F3_REM:                     neg_next = sign_a;
            default:                    neg_next = 1'b0;
        endcase
        div_zero    = funct3[2] && (rs2_val == '0);
        div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
        special     = div_zero || div_ovf;
        special_val = '0;
        if (div_zero)
            special_val = funct3[1] ? rs1_val : '1;
        else if (div_ovf)
            special_val = funct3[1] ? '0 : rs1_val;
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .mode    (op_f3[2]),
        .hi_in   (acc_hi),
        .lo_in   (acc_lo),
        .operand (operand_b),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    always_comb begin
        product     = {acc_hi[XLEN-1:0], acc_lo};
        product_fix = neg_res ? -product : product;
        fixed       = '0;
        case (op_f3)
            F3_MUL:                        fixed = product_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fixed = product_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fixed = neg_res ? -acc_lo : acc_lo;
            F3_REM, F3_REMU:               fixed = neg_res ? -acc_hi[XLEN-1:0] : acc_hi[XLEN-1:0];
            default:                       fixed = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state   = state;
        ready        = (state == IDLE);
        busy         = (start && ready) || (state == CALC) || (state == FIXUP);
        result_valid = (state == DONE);
        case (state)
            IDLE:    if (accept) next_state = special ? DONE : CALC;
            CALC:    if (flush) next_state = IDLE;
                     else if (count == 6'(XLEN-1)) next_state = FIXUP;
            FIXUP:   next_state = flush ? IDLE : DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Multiply keeps the multiplier in lo and multiplicand as the step operand;
    // divide keeps the dividend in lo and the divisor as the step operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            op_f3      <= '0;
            neg_res    <= 1'b0;
            rd_pending <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            operand_b  <= '0;
            result     <= '0;
            rd_out     <= '0;
        end else if (accept) begin
            count      <= '0;
            op_f3      <= funct3;
            neg_res    <= neg_next;
            rd_pending <= rd_in;
            acc_hi     <= '0;
            acc_lo     <= funct3[2] ? abs_a : abs_b;
            operand_b  <= funct3[2] ? abs_b : abs_a;
            if (special) begin
                result <= special_val;
                rd_out <= rd_in;
            end
        end else if (state == CALC && !flush) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count + 6'd1;
        end else if (state == FIXUP && !flush) begin
            result <= fixed;
            rd_out <= rd_pending;
        end
    end

endmodule
